// File: rtl/instr_prefetch_if.sv
// Bus bundle between the instruction prefetch unit and its environment:
// run control, instruction memory read port and the decoder handshake.
interface instr_prefetch_if #(
  parameter int INSTR_W = 64,
  parameter int ADDR_W  = 16
);
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  instr_count;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] out_instr;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_seq;
  logic               busy;
  logic               done;

  // Environment side: launches runs, models memory, plays the decoder.
  modport master (
    output start, start_addr, instr_count, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_instr, out_valid, out_seq, busy, done
  );

  // Prefetch unit side.
  modport slave (
    input  start, start_addr, instr_count, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_instr, out_valid, out_seq, busy, done
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: streams a run of instructions from memory into a
// small buffer, issuing reads only while a buffer slot is guaranteed for the
// returning word, and stops early on a HALT opcode.
module instr_prefetch_unit #(
  parameter int         INSTR_W           = 64,
  parameter int         ADDR_W            = 16,
  parameter int         INSTR_ADDR_OFFSET = 0,
  parameter int         MEM_LAT           = 1,
  parameter int         BUF_DEPTH         = 4,
  parameter logic [7:0] HALT_OPCODE       = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  instr_prefetch_if.slave   bus
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + MEM_LAT + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   seq_q, seq_d;
  logic [MEM_LAT-1:0]  track_q, track_d;
  logic                halt_q, halt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]         occ_q, occ_d;
  logic [INSTR_W-1:0]  buf_q [BUF_DEPTH];

  logic [CW-1:0]       in_flight_s;
  logic                credit_s;
  logic                ret_valid_s;
  logic                ret_halt_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                issue_s;
  logic                last_issue_s;

  // Count reads still in flight from the latency tracker.
  always_comb begin
    in_flight_s = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      in_flight_s = in_flight_s + CW'(track_q[i]);
    end
  end

  // Issue and return-path qualifiers; a HALT word blocks issue in its own cycle.
  always_comb begin
    credit_s     = (in_flight_s + CW'(occ_q)) < CW'(BUF_DEPTH);
    ret_valid_s  = track_q[MEM_LAT-1];
    ret_halt_s   = ret_valid_s && !halt_q &&
                   (bus.mem_rdata[INSTR_W-1 -: 8] == HALT_OPCODE);
    wr_en_s      = ret_valid_s && !halt_q && !ret_halt_s;
    rd_en_s      = (occ_q != '0) && bus.out_ready;
    issue_s      = (state_q == ST_FETCH) && credit_s && !ret_halt_s;
    last_issue_s = issue_s && (count_q != '0) &&
                   ((issue_cnt_q + ADDR_W'(1)) == count_q);
  end

  // Next-state logic for the run FSM, counters, tracker and buffer pointers.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issue_cnt_d = issue_s ? (issue_cnt_q + ADDR_W'(1)) : issue_cnt_q;
    seq_d       = rd_en_s ? (seq_q + ADDR_W'(1)) : seq_q;
    halt_d      = ret_halt_s ? 1'b1 : halt_q;
    wr_ptr_d    = wr_en_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = rd_en_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    track_d     = '0;
    track_d[0]  = issue_s;
    for (int i = 1; i < MEM_LAT; i++) begin
      track_d[i] = track_q[i-1];
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          base_d      = bus.start_addr + ADDR_W'(INSTR_ADDR_OFFSET);
          count_d     = bus.instr_count;
          issue_cnt_d = '0;
          seq_d       = '0;
          halt_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (ret_halt_s || last_issue_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if ((in_flight_s == '0) && (occ_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control and status registers; reset also discards in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issue_cnt_q <= '0;
      seq_q       <= '0;
      track_q     <= '0;
      halt_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
      seq_q       <= seq_d;
      track_q     <= track_d;
      halt_q      <= halt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Buffer storage; contents are meaningless while occupancy is zero.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  // Outputs derive from registered state only, except read issue which is
  // cut off the moment a HALT word returns.
  always_comb begin
    bus.mem_rd_en = issue_s;
    bus.mem_addr  = issue_s ? (base_q + issue_cnt_q) : '0;
    bus.out_instr = buf_q[rd_ptr_q];
    bus.out_valid = (occ_q != '0);
    bus.out_seq   = seq_q;
    bus.busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    bus.done      = (state_q == ST_DONE);
  end

endmodule
